// File: rtl/msg_validity_checker.sv
// -----------------------------------------------------------------------------
// msg_validity_checker
//
// Reads the decrypted RC4 message back from RAM one byte at a time and decides
// whether the candidate key produced printable plaintext ('a'..'z' or space).
// The key-search scheduler treats key_invalid as its "try the next key" request.
//
// Optional feature macro: CHECKER_EARLY_ABORT_EN
//   undefined (default): all MSG_LEN bytes are always scanned, so the latency
//                        from start to check_done is fixed at 3*MSG_LEN+1.
//   defined            : the first bad byte ends the scan immediately.
//
// Ports
//   clk          system clock, all state on the rising edge
//   reset_n      asynchronous active-low reset
//   sig_start    start request, only sampled while idle
//   data_in      RAM read data, valid one full cycle after check_addr
//   check_addr   RAM read address
//   check_done   one-cycle pulse when a scan finishes
//   key_valid    level, last scan passed; cleared by the next accepted start
//   key_invalid  one-cycle pulse with check_done when the scan failed
//   fail_index   address of the first failing byte, 0 when the scan passed
//   state_dbg    current FSM state (IDLE=0, ADDR=1, WAIT=2, CHECK=3, DONE=4)
//
// Handshake: sig_start is a level request honoured only in IDLE; there is no
// back-pressure and no queueing, a request seen outside IDLE is dropped.
// -----------------------------------------------------------------------------
module msg_validity_checker #(
   parameter int          MSG_LEN = 32,
   parameter int          ADDR_W  = 5,
   parameter logic [7:0]  CHAR_LO = 8'd97,
   parameter logic [7:0]  CHAR_HI = 8'd122,
   parameter logic [7:0]  CHAR_SP = 8'd32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sig_start,
   input  logic [7:0]        data_in,
   output logic [ADDR_W-1:0] check_addr,
   output logic              check_done,
   output logic              key_valid,
   output logic              key_invalid,
   output logic [ADDR_W-1:0] fail_index,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

   state_e              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   fail_idx_q;
   logic                fail_q;
   logic                done_q;
   logic                valid_q;
   logic                invalid_q;
   logic                byte_ok;

   // Inclusive unsigned letter range, plus the single extra space byte.
   assign byte_ok = ((data_in >= CHAR_LO) && (data_in <= CHAR_HI)) ||
                    (data_in == CHAR_SP);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         fail_idx_q <= '0;
         fail_q     <= 1'b0;
         done_q     <= 1'b0;
         valid_q    <= 1'b0;
         invalid_q  <= 1'b0;
      end else begin
         // Pulses default low; only the DONE state raises them.
         done_q    <= 1'b0;
         invalid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (sig_start) begin
                  state_q    <= S_ADDR;
                  addr_q     <= '0;
                  valid_q    <= 1'b0;
                  fail_q     <= 1'b0;
                  fail_idx_q <= '0;
               end
            end
            S_ADDR:  state_q <= S_WAIT;
            // RAM latency: data for addr_q lands during this cycle.
            S_WAIT:  state_q <= S_CHECK;
            S_CHECK: begin
               // Only the first failing address is kept.
               if (!byte_ok && !fail_q) begin
                  fail_q     <= 1'b1;
                  fail_idx_q <= addr_q;
               end
`ifdef CHECKER_EARLY_ABORT_EN
               if (!byte_ok || (addr_q == LAST_ADDR)) begin
                  state_q <= S_DONE;
               end else begin
                  addr_q  <= addr_q + 1'b1;
                  state_q <= S_ADDR;
               end
`else
               if (addr_q == LAST_ADDR) begin
                  state_q <= S_DONE;
               end else begin
                  addr_q  <= addr_q + 1'b1;
                  state_q <= S_ADDR;
               end
`endif
            end
            S_DONE: begin
               done_q    <= 1'b1;
               valid_q   <= !fail_q;
               invalid_q <= fail_q;
               state_q   <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign check_addr  = addr_q;
   assign check_done  = done_q;
   assign key_valid   = valid_q;
   assign key_invalid = invalid_q;
   assign fail_index  = fail_idx_q;
   assign state_dbg   = state_q;

endmodule
